// File: rtl/riscv_core_div.sv
// Iterative radix-2 restoring divider for RV64 M: DIV/DIVU/REM/REMU and W forms.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass CALC.
module riscv_core_div #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_div_valid,
  output logic            o_div_ready,
  input  logic [XLEN-1:0] i_div_srcA,
  input  logic [XLEN-1:0] i_div_srcB,
  input  logic [1:0]      i_div_control,
  input  logic            i_div_isword,
  input  logic            i_div_flush,
  output logic            o_div_valid,
  output logic [XLEN-1:0] o_div_result
);

  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic            accept;
  logic            sgn_in;
  logic            neg_a, neg_b;
  logic            div_zero, ovf, special;
  logic [XLEN-1:0] a_ext, b_ext;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] min_val;

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]   cnt_q;
  logic            rem_sel_q, word_q;
  logic            q_neg_q, r_neg_q;

  logic [XLEN:0]   shl;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] q_fix, r_fix, sel, fin;
  logic            done_ok;

  assign accept = i_div_valid & o_div_ready
                & ~i_div_flush;

  always_comb begin
    sgn_in = ~i_div_control[0];
    if (i_div_isword) begin
      a_ext = {{HW{sgn_in & i_div_srcA[HW-1]}},
               i_div_srcA[HW-1:0]};
      b_ext = {{HW{sgn_in & i_div_srcB[HW-1]}},
               i_div_srcB[HW-1:0]};
      min_val = {{(HW+1){1'b1}},
                 {(HW-1){1'b0}}};
    end else begin
      a_ext   = i_div_srcA;
      b_ext   = i_div_srcB;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    neg_a    = sgn_in & a_ext[XLEN-1];
    neg_b    = sgn_in & b_ext[XLEN-1];
    abs_a    = neg_a ? -a_ext : a_ext;
    abs_b    = neg_b ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = sgn_in & (a_ext == min_val)
             & (&b_ext);
    special  = div_zero | ovf;
  end

  // Restoring step: partial remainder grows by the next dividend bit
  assign shl    = {rem_q, quo_q[XLEN-1]};
  assign ge     = shl >= {1'b0, dvs_q};
  assign rem_nx = ge ? shl[XLEN-1:0] - dvs_q
                     : shl[XLEN-1:0];

  assign q_fix = q_neg_q ? -quo_q : quo_q;
  assign r_fix = r_neg_q ? -rem_q : rem_q;
  assign sel   = rem_sel_q ? r_fix : q_fix;
  assign fin   = word_q
               ? {{HW{sel[HW-1]}}, sel[HW-1:0]}
               : sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_div_flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else if (accept) begin
      rem_sel_q <= i_div_control[1];
      word_q    <= i_div_isword;
      dvs_q     <= abs_b;
      cnt_q     <= i_div_isword ? CW'(HW - 1)
                                : CW'(XLEN - 1);
      // Special cases preload the final unsigned-form answer
      if (special) begin
        quo_q   <= div_zero ? '1 : a_ext;
        rem_q   <= div_zero ? a_ext : '0;
        q_neg_q <= 1'b0;
        r_neg_q <= 1'b0;
      end else begin
        quo_q   <= i_div_isword ? abs_a << HW
                                : abs_a;
        rem_q   <= '0;
        q_neg_q <= neg_a ^ neg_b;
        r_neg_q <= neg_a;
      end
    end else if (state_q == CALC
                 && !i_div_flush) begin
      rem_q <= rem_nx;
      quo_q <= {quo_q[XLEN-2:0], ge};
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done_ok = (state_q == DONE)
                 & ~i_div_flush;

  // Ready stays low during the valid pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_div_valid  <= 1'b0;
      o_div_result <= '0;
      o_div_ready  <= 1'b1;
    end else begin
      o_div_valid <= done_ok;
      o_div_ready <= (state_d == IDLE) & ~done_ok;
      if (done_ok) begin
        o_div_result <= fin;
      end
    end
  end

endmodule
